// File: rtl/aes_pipe_scheduler.sv
// aes_pipe_scheduler: key/block front-end for a non-stallable pipelined AES-128 core; optional stats ports under AES_SCHED_STATS_EN
module aes_pipe_scheduler #(
  parameter int DATA_W  = 128,
  parameter int KEY_LEN = 128,
  parameter int KEY_LAT = 10,
  parameter int CREDITS = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid_in,
  output logic               key_ready_out,
  input  logic [KEY_LEN-1:0] key_in,
  input  logic               blk_valid_in,
  output logic               blk_ready_out,
  input  logic [DATA_W-1:0]  blk_in,
  output logic               core_key_valid,
  output logic [KEY_LEN-1:0] core_cipher_key,
  output logic               core_data_valid,
  output logic [DATA_W-1:0]  core_plain_text,
  input  logic               core_valid_out,
  input  logic [DATA_W-1:0]  core_cipher_text,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               credit_ret,
  output logic               busy,
  output logic               err_sticky
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_blocks,
  output logic [31:0]        stat_stall
`endif
);
  localparam int LAT_W = $clog2(KEY_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(KEY_LAT - 1);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  typedef enum logic [1:0] {IDLE, KEYLOAD, READY, DRAIN} state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] credits;
  logic [CNT_W-1:0] inflight;
  logic             key_fire;
  logic             blk_fire;
  logic             res_ok;
  logic             ret_ok;

  assign key_ready_out = (state == IDLE) || (state == READY && key_valid_in && inflight == '0);
  assign blk_ready_out = (state == READY) && (credits != '0) && !key_valid_in;
  assign key_fire      = key_valid_in && key_ready_out;
  assign blk_fire      = blk_valid_in && blk_ready_out;
  assign res_ok        = core_valid_out && (inflight != '0);
  assign ret_ok        = credit_ret && (credits != CRED_MAX);
  assign busy          = !(state == IDLE || state == READY) || (inflight != '0);

  // Control FSM: key load and latency wait, drain before rekey; key register and load pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      core_key_valid  <= 1'b0;
      core_cipher_key <= '0;
    end else begin
      core_key_valid <= key_fire;
      if (key_fire) core_cipher_key <= key_in;
      case (state)
        IDLE: if (key_fire) begin
          state   <= KEYLOAD;
          lat_cnt <= '0;
        end
        KEYLOAD: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LAT_LAST) state <= READY;
        end
        READY: if (key_fire) begin
          state   <= KEYLOAD;
          lat_cnt <= '0;
        end else if (key_valid_in && inflight != '0) begin
          state <= DRAIN;
        end
        DRAIN: if (!key_valid_in || inflight == '0) state <= READY;
        default: state <= IDLE;
      endcase
    end
  end

  // Issue register toward the core and single-stage result register toward downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_data_valid <= 1'b0;
      core_plain_text <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
    end else begin
      core_data_valid <= blk_fire;
      if (blk_fire) core_plain_text <= blk_in;
      out_valid <= core_valid_out;
      out_data  <= core_cipher_text;
    end
  end

  // Credit and in-flight accounting; protocol violations latch the error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits    <= CRED_MAX;
      inflight   <= '0;
      err_sticky <= 1'b0;
    end else begin
      inflight   <= inflight + CNT_W'(blk_fire) - CNT_W'(res_ok);
      credits    <= credits - CNT_W'(blk_fire) + CNT_W'(ret_ok);
      err_sticky <= err_sticky
                  | (core_valid_out && (inflight == '0 || state == IDLE || state == KEYLOAD))
                  | (credit_ret && credits == CRED_MAX);
    end
  end

`ifdef AES_SCHED_STATS_EN
  // Free-running statistics, untouched by rekey
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_blocks <= '0;
      stat_stall  <= '0;
    end else begin
      if (blk_fire) stat_blocks <= stat_blocks + 32'd1;
      if (blk_valid_in && !blk_ready_out && (state == READY || state == DRAIN)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// tb_aes_pipe_scheduler: scoreboard bench for aes_pipe_scheduler with a fixed-latency core stub
module tb_aes_pipe_scheduler;
  localparam int LAT = 12;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2     = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
  localparam logic [127:0] K3     = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_valid_in = 1'b0;
  logic         key_ready_out;
  logic [127:0] key_in = '0;
  logic         blk_valid_in = 1'b0;
  logic         blk_ready_out;
  logic [127:0] blk_in = '0;
  logic         core_key_valid;
  logic [127:0] core_cipher_key;
  logic         core_data_valid;
  logic [127:0] core_plain_text;
  logic         core_valid_out;
  logic [127:0] core_cipher_text;
  logic         out_valid;
  logic [127:0] out_data;
  logic         credit_ret = 1'b0;
  logic         busy;
  logic         err_sticky;
`ifdef AES_SCHED_STATS_EN
  logic [31:0]  stat_blocks;
  logic [31:0]  stat_stall;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int owed = 0;
  logic [127:0] cur_key = '0;
  logic [127:0] exp_out[$];
  logic [127:0] exp_pt[$];
  int           exp_due[$];
  logic         inj_v = 1'b0;
  logic [127:0] inj_d = '0;
  logic         sv[LAT];
  logic [127:0] sd[LAT];

  aes_pipe_scheduler dut (
    .clk(clk), .reset(reset),
    .key_valid_in(key_valid_in), .key_ready_out(key_ready_out), .key_in(key_in),
    .blk_valid_in(blk_valid_in), .blk_ready_out(blk_ready_out), .blk_in(blk_in),
    .core_key_valid(core_key_valid), .core_cipher_key(core_cipher_key),
    .core_data_valid(core_data_valid), .core_plain_text(core_plain_text),
    .core_valid_out(core_valid_out), .core_cipher_text(core_cipher_text),
    .out_valid(out_valid), .out_data(out_data),
    .credit_ret(credit_ret), .busy(busy), .err_sticky(err_sticky)
`ifdef AES_SCHED_STATS_EN
    , .stat_blocks(stat_blocks), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] aes_stub(input logic [127:0] k, input logic [127:0] p);
    return (k == FIPS_K && p == FIPS_P) ? FIPS_C : (k ^ p);
  endfunction

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [127:0] d);
    exp_pt.push_back(d);
    exp_due.push_back(cyc + 1);
    exp_out.push_back(aes_stub(cur_key, d));
    owed++;
  endfunction

  // Core stub: fixed latency, resets with the scheduler, plus an injection path for spurious results
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        sv[i] <= 1'b0;
        sd[i] <= '0;
      end
    end else begin
      sv[0] <= core_data_valid;
      sd[0] <= aes_stub(core_cipher_key, core_plain_text);
      for (int i = 1; i < LAT; i++) begin
        sv[i] <= sv[i-1];
        sd[i] <= sd[i-1];
      end
    end
  end
  assign core_valid_out   = sv[LAT-1] | inj_v;
  assign core_cipher_text = inj_v ? inj_d : sd[LAT-1];

  // Monitor: pops expectations whenever the DUT presents an issue or a result
  always @(negedge clk) begin
    if (reset) begin
      if (core_data_valid) begin
        if (exp_pt.size() == 0) check("unexpected_issue", core_data_valid, 1'b0);
        else begin
          check("plain_text", core_plain_text, exp_pt.pop_front());
          check("issue_cycle", cyc, exp_due.pop_front());
          check("issue_key", core_cipher_key, cur_key);
        end
      end
      if (out_valid) begin
        if (exp_out.size() == 0) check("unexpected_out", out_valid, 1'b0);
        else check("out_data", out_data, exp_out.pop_front());
      end
    end
  end

  task automatic send_key(input logic [127:0] k, input int budget, output bit ok);
    key_valid_in = 1'b1;
    key_in = k;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (key_ready_out) begin
        ok = 1'b1;
        cur_key = k;
      end
      @(negedge clk);
    end
    key_valid_in = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] d, input int budget, output bit ok);
    blk_valid_in = 1'b1;
    blk_in = d;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (blk_ready_out) begin
        ok = 1'b1;
        push(d);
      end
      @(negedge clk);
    end
    blk_valid_in = 1'b0;
  endtask

  task automatic ret_credit();
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    owed--;
  endtask

  task automatic return_all();
    while (owed > 0) ret_credit();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (exp_out.size() != 0 || exp_pt.size() != 0); i++) @(negedge clk);
    check("idle_timeout", exp_out.size() + exp_pt.size(), 0);
  endtask

  task automatic reset_checks(input string p);
    check({p, "_key_ready"}, key_ready_out, 1'b1);
    check({p, "_blk_ready"}, blk_ready_out, 1'b0);
    check({p, "_core_key_valid"}, core_key_valid, 1'b0);
    check({p, "_core_cipher_key"}, core_cipher_key, '0);
    check({p, "_core_data_valid"}, core_data_valid, 1'b0);
    check({p, "_core_plain_text"}, core_plain_text, '0);
    check({p, "_out_valid"}, out_valid, 1'b0);
    check({p, "_out_data"}, out_data, '0);
    check({p, "_busy"}, busy, 1'b0);
    check({p, "_err"}, err_sticky, 1'b0);
    check({p, "_credits"}, dut.credits, 16);
    check({p, "_inflight"}, dut.inflight, 0);
  endtask

  task automatic inject(input logic [127:0] d);
    inj_v = 1'b1;
    inj_d = d;
    exp_out.push_back(d);
    @(negedge clk);
    inj_v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    int lows;
    int pulses;
    bit got;
    repeat (3) @(negedge clk);
    #1 reset_checks("por");
    reset = 1'b1;
    @(negedge clk);

    send_key(FIPS_K, 5, ok);
    check("t1_key_accept", ok, 1'b1);
    #1;
    check("t1_key_reg", core_cipher_key, FIPS_K);
    lows = 0;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      pulses += int'(core_key_valid);
      lows += int'(!blk_ready_out);
      if (i < 10) begin
        @(negedge clk);
        #1;
      end
    end
    check("t1_ready_low_cycles", lows, 10);
    check("t1_ready_high", blk_ready_out, 1'b1);
    check("t1_key_pulses", pulses, 1);
    @(negedge clk);

    send_blk(FIPS_P, 5, ok);
    check("t2_accept", ok, 1'b1);
    wait_idle(40);
    return_all();

    n = 0;
    blk_valid_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      blk_in = 128'ha5a5_0000_0000_0000_0000_0000_0000_0000 + 128'(n);
      #1;
      if (blk_ready_out) begin
        push(blk_in);
        n++;
      end
      @(negedge clk);
    end
    check("t3_issued_no_credit", n, 16);
    #1 check("t3_ready_zero", blk_ready_out, 1'b0);
    ret_credit();
    for (int i = 0; i < 10; i++) begin
      blk_in = 128'ha5a5_0000_0000_0000_0000_0000_0000_0000 + 128'(n);
      #1;
      if (blk_ready_out) begin
        push(blk_in);
        n++;
      end
      @(negedge clk);
    end
    check("t3_issued_after_credit", n, 17);
    blk_valid_in = 1'b0;
    wait_idle(40);
    return_all();

    for (int i = 0; i < 5; i++) begin
      send_blk(128'h1111_2222_3333_4444_0000_0000_0000_0000 + 128'(i), 3, ok);
      check("t4_blk_accept", ok, 1'b1);
    end
    key_valid_in = 1'b1;
    key_in = K2;
    blk_valid_in = 1'b1;
    blk_in = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      check("t4_blk_blocked", blk_ready_out, 1'b0);
      check("t4_key_early", key_ready_out && (exp_out.size() != 0), 1'b0);
      if (exp_out.size() != 0) check("t4_busy", busy, 1'b1);
      if (key_ready_out) begin
        got = 1'b1;
        cur_key = K2;
      end
      @(negedge clk);
    end
    key_valid_in = 1'b0;
    blk_valid_in = 1'b0;
    check("t4_key_accept", got, 1'b1);
    for (int i = 0; i < 12; i++) begin
      #1 check("t4_key_stable", core_cipher_key, K2);
      @(negedge clk);
    end
    send_blk(128'h0123_4567_89ab_cdef_0000_1111_2222_3333, 5, ok);
    check("t4_new_key_blk", ok, 1'b1);
    send_blk(128'hffff_0000_ffff_0000_1234_5678_9abc_def0, 5, ok);
    check("t4_new_key_blk", ok, 1'b1);
    wait_idle(40);
    return_all();

    for (int i = 0; i < 3; i++) send_blk(128'h7777 + 128'(i), 3, ok);
    key_valid_in = 1'b1;
    key_in = K3;
    #1 check("t4d_key_ready", key_ready_out, 1'b0);
    @(negedge clk);
    #1;
    check("t4d_drain_blk_ready", blk_ready_out, 1'b0);
    check("t4d_drain_key_ready", key_ready_out, 1'b0);
    check("t4d_drain_busy", busy, 1'b1);
    key_valid_in = 1'b0;
    @(negedge clk);
    #1;
    check("t4d_back_to_ready", blk_ready_out, 1'b1);
    check("t4d_no_key_pulse", core_key_valid, 1'b0);
    check("t4d_key_kept", core_cipher_key, K2);
    @(negedge clk);
    wait_idle(40);
    return_all();

    #1 check("t5_err_clear", err_sticky, 1'b0);
    @(negedge clk);
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    #1;
    check("t5_err_credit", err_sticky, 1'b1);
    check("t5_credits_sat", dut.credits, 16);
    @(negedge clk);

    for (int i = 0; i < 3; i++) send_blk(128'h9999 + 128'(i), 3, ok);
    key_valid_in = 1'b1;
    key_in = K3;
    @(negedge clk);
    #2;
    reset = 1'b0;
    key_valid_in = 1'b0;
    exp_out.delete();
    exp_pt.delete();
    exp_due.delete();
    owed = 0;
    #1 reset_checks("t6");
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    inject(128'h5bad_5bad_0000_0000_0000_0000_0000_0001);
    #1;
    check("t5_err_spurious_idle", err_sticky, 1'b1);
    check("t5_inflight_idle", dut.inflight, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("t5_err_reset", err_sticky, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    send_key(K3, 5, ok);
    check("t5_key_accept", ok, 1'b1);
    repeat (11) @(negedge clk);
    #1 check("t5_ready", blk_ready_out, 1'b1);
    @(negedge clk);
    inject(128'h5bad_5bad_0000_0000_0000_0000_0000_0002);
    #1;
    check("t5_err_spurious_ready", err_sticky, 1'b1);
    check("t5_inflight_ready", dut.inflight, 0);
    check("t5_still_ready", blk_ready_out, 1'b1);
    @(negedge clk);
    wait_idle(10);

    check("queues_empty", exp_out.size() + exp_pt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
